// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//
// Shares the register unit's two writeback ports among numReq result
// producers. Each cycle it grants up to two pending results in round-robin
// order. The two grants in one cycle never target the same destination
// register. Granted results appear on the registered reg1/reg2 writeback
// ports on the following clock edge.
//
// Ports
//   clock_i                 clock, all state updates on the rising edge
//   reset_i                 synchronous, active-high reset
//   reqValid_i[numReq]      requester i has a result pending
//   reqData_i               result data, requester i in slice i (addressSize bits each)
//   reqAddr_i               destination register, requester i in slice i (regWidth bits each)
//   reqReady_o[numReq]      combinational grant; transfer happens when valid & ready
//   reg1isWriteback_o       writeback port 1 valid
//   reg1WritebackAddress_o  writeback port 1 register
//   reg1WritebackData_o     writeback port 1 data
//   reg2isWriteback_o       writeback port 2 valid
//   reg2WritebackAddress_o  writeback port 2 register
//   reg2WritebackData_o     writeback port 2 data
//   contentionCount_o       saturating count of cycles with an ungranted valid request

module writeback_arbiter #(
   parameter int numReq      = 4,
   parameter int addressSize = 64,
   parameter int regWidth    = 5,
   parameter int cntWidth    = 16
) (
   input  logic                          clock_i,
   input  logic                          reset_i,
   input  logic [numReq-1:0]             reqValid_i,
   input  logic [numReq*addressSize-1:0] reqData_i,
   input  logic [numReq*regWidth-1:0]    reqAddr_i,
   output logic [numReq-1:0]             reqReady_o,
   output logic                          reg1isWriteback_o,
   output logic [regWidth-1:0]           reg1WritebackAddress_o,
   output logic [addressSize-1:0]        reg1WritebackData_o,
   output logic                          reg2isWriteback_o,
   output logic [regWidth-1:0]           reg2WritebackAddress_o,
   output logic [addressSize-1:0]        reg2WritebackData_o,
   output logic [cntWidth-1:0]           contentionCount_o
);

   localparam int ptrWidth = (numReq > 1) ? $clog2(numReq) : 1;
   // One extra bit so ptr + offset never overflows before the modulo fold.
   localparam int sumWidth = ptrWidth + 1;
   localparam logic [ptrWidth-1:0] lastIdx = ptrWidth'(numReq - 1);

   logic [ptrWidth-1:0] ptr;
   logic [ptrWidth-1:0] ptr_next;

   logic [regWidth-1:0]    req_addr [numReq];
   logic [addressSize-1:0] req_data [numReq];

   logic                slot1_found;
   logic                slot2_found;
   logic [ptrWidth-1:0] slot1_idx;
   logic [ptrWidth-1:0] slot2_idx;
   logic [regWidth-1:0] slot1_addr;
   logic [sumWidth-1:0] scan_sum;
   logic [ptrWidth-1:0] scan_idx;
   logic                contention;

   // Unpack the flat requester buses into per-requester arrays so the
   // selection logic can index them by requester number.
   for (genvar g = 0; g < numReq; g++) begin : g_unpack
      assign req_addr[g] = reqAddr_i[g*regWidth +: regWidth];
      assign req_data[g] = reqData_i[g*addressSize +: addressSize];
   end

   // Round-robin scan starting at ptr. The first valid requester becomes
   // slot1; the next valid requester whose destination differs from slot1's
   // becomes slot2. Requesters aiming at slot1's register are skipped so the
   // register unit never sees two writes to one register in a cycle.
   // Nothing is granted while reset is asserted.
   always_comb begin
      slot1_found = 1'b0;
      slot2_found = 1'b0;
      slot1_idx   = '0;
      slot2_idx   = '0;
      slot1_addr  = '0;
      scan_sum    = '0;
      scan_idx    = '0;
      reqReady_o  = '0;
      for (int k = 0; k < numReq; k++) begin
         scan_sum = {1'b0, ptr} + sumWidth'(k);
         if (scan_sum >= sumWidth'(numReq)) begin
            scan_sum = scan_sum - sumWidth'(numReq);
         end
         scan_idx = scan_sum[ptrWidth-1:0];
         if (!reset_i && reqValid_i[scan_idx]) begin
            if (!slot1_found) begin
               slot1_found = 1'b1;
               slot1_idx   = scan_idx;
               slot1_addr  = req_addr[scan_idx];
            end else if (!slot2_found && (req_addr[scan_idx] != slot1_addr)) begin
               slot2_found = 1'b1;
               slot2_idx   = scan_idx;
            end
         end
      end
      if (slot1_found) begin
         reqReady_o[slot1_idx] = 1'b1;
      end
      if (slot2_found) begin
         reqReady_o[slot2_idx] = 1'b1;
      end
   end

   assign contention = |(reqValid_i & ~reqReady_o);

   // The pointer moves just past the last requester served this cycle, so
   // the requester after it gets first pick next time.
   always_comb begin
      ptr_next = ptr;
      if (slot2_found) begin
         ptr_next = (slot2_idx == lastIdx) ? '0 : slot2_idx + 1'b1;
      end else if (slot1_found) begin
         ptr_next = (slot1_idx == lastIdx) ? '0 : slot1_idx + 1'b1;
      end
   end

   // State register: pointer, contention counter and the writeback ports.
   // A port without a grant drops its valid but keeps its last address and
   // data. The counter sticks at all-ones instead of wrapping.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         ptr                    <= '0;
         contentionCount_o      <= '0;
         reg1isWriteback_o      <= 1'b0;
         reg1WritebackAddress_o <= '0;
         reg1WritebackData_o    <= '0;
         reg2isWriteback_o      <= 1'b0;
         reg2WritebackAddress_o <= '0;
         reg2WritebackData_o    <= '0;
      end else begin
         ptr <= ptr_next;
         if (contention && (contentionCount_o != '1)) begin
            contentionCount_o <= contentionCount_o + 1'b1;
         end
         reg1isWriteback_o <= slot1_found;
         if (slot1_found) begin
            reg1WritebackAddress_o <= req_addr[slot1_idx];
            reg1WritebackData_o    <= req_data[slot1_idx];
         end
         reg2isWriteback_o <= slot2_found;
         if (slot2_found) begin
            reg2WritebackAddress_o <= req_addr[slot2_idx];
            reg2WritebackData_o    <= req_data[slot2_idx];
         end
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter
//
// Self-checking bench for writeback_arbiter with four requesters. A table of
// hand-derived vectors gives, for each cycle, the requests presented, the
// grants that must appear and which requester must land on each port. The
// port contents are pushed into a scoreboard queue when the vector is driven
// and compared after the next rising edge. Hand-written sequences cover
// reset, counter saturation and a reset in the middle of traffic.

module tb_writeback_arbiter;

   localparam int numReq      = 4;
   localparam int addressSize = 64;
   localparam int regWidth    = 5;
   localparam int cntWidth    = 16;

   logic                          clock = 1'b0;
   logic                          reset = 1'b1;
   logic [numReq-1:0]             req_valid = '0;
   logic [numReq*addressSize-1:0] req_data = '0;
   logic [numReq*regWidth-1:0]    req_addr = '0;
   logic [numReq-1:0]             req_ready;
   logic                          p1_valid;
   logic [regWidth-1:0]           p1_addr;
   logic [addressSize-1:0]        p1_data;
   logic                          p2_valid;
   logic [regWidth-1:0]           p2_addr;
   logic [addressSize-1:0]        p2_data;
   logic [cntWidth-1:0]           cont_count;

   int checks   = 0;
   int failures = 0;

   // One table row: requests presented, grants required, and which
   // requester must appear on port 1 / port 2 (-1 for none).
   typedef struct packed {
      logic [3:0]      valid;
      logic [3:0][4:0] addr;
      logic [3:0]      ready;
      int              p1;
      int              p2;
   } vec_t;

   // Port contents required one edge after a vector is driven.
   typedef struct packed {
      logic        p1v;
      logic [4:0]  p1a;
      logic [63:0] p1d;
      logic        p2v;
      logic [4:0]  p2a;
      logic [63:0] p2d;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];

   logic [4:0]  last1_addr = '0;
   logic [63:0] last1_data = '0;
   logic [4:0]  last2_addr = '0;
   logic [63:0] last2_data = '0;
   logic [15:0] exp_cnt    = '0;

   writeback_arbiter #(
      .numReq(numReq),
      .addressSize(addressSize),
      .regWidth(regWidth),
      .cntWidth(cntWidth)
   ) dut (
      .clock_i(clock),
      .reset_i(reset),
      .reqValid_i(req_valid),
      .reqData_i(req_data),
      .reqAddr_i(req_addr),
      .reqReady_o(req_ready),
      .reg1isWriteback_o(p1_valid),
      .reg1WritebackAddress_o(p1_addr),
      .reg1WritebackData_o(p1_data),
      .reg2isWriteback_o(p2_valid),
      .reg2WritebackAddress_o(p2_addr),
      .reg2WritebackData_o(p2_data),
      .contentionCount_o(cont_count)
   );

   always #5 clock = ~clock;

   // Result data is tied to requester and destination so a held request
   // keeps presenting the same value.
   function automatic logic [63:0] mk_data(input logic [4:0] a, input int i);
      return 64'hDA7A_0000_0000_0000 | (64'(a) << 8) | 64'(i);
   endfunction

   function automatic vec_t mk_vec(input logic [3:0] valid,
                                   input logic [4:0] a3, input logic [4:0] a2,
                                   input logic [4:0] a1, input logic [4:0] a0,
                                   input logic [3:0] ready, input int p1, input int p2);
      vec_t v;
      v.valid = valid;
      v.addr  = {a3, a2, a1, a0};
      v.ready = ready;
      v.p1    = p1;
      v.p2    = p2;
      return v;
   endfunction

   task automatic compareValue(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic drive(input logic [3:0] valid, input logic [3:0][4:0] addr);
      req_valid = valid;
      for (int i = 0; i < numReq; i++) begin
         req_addr[i*regWidth +: regWidth]       = valid[i] ? addr[i] : 5'd0;
         req_data[i*addressSize +: addressSize] = valid[i] ? mk_data(addr[i], i) : 64'd0;
      end
   endtask

   // Pop the oldest expected port state and compare against the DUT.
   task automatic checkOutput(input int tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard_empty vec %0d: got 0 entries, expected 1", tag);
         return;
      end
      e = exp_q.pop_front();
      compareValue($sformatf("v%0d_p1_valid", tag), 64'(p1_valid), 64'(e.p1v));
      compareValue($sformatf("v%0d_p1_addr", tag), 64'(p1_addr), 64'(e.p1a));
      compareValue($sformatf("v%0d_p1_data", tag), p1_data, e.p1d);
      compareValue($sformatf("v%0d_p2_valid", tag), 64'(p2_valid), 64'(e.p2v));
      compareValue($sformatf("v%0d_p2_addr", tag), 64'(p2_addr), 64'(e.p2a));
      compareValue($sformatf("v%0d_p2_data", tag), p2_data, e.p2d);
      compareValue($sformatf("v%0d_count", tag), 64'(cont_count), 64'(e.cnt));
   endtask

   // Drive one vector away from the clock edge, check the combinational
   // grants, queue the port contents expected after the edge, then check.
   task automatic applyStimulus(input vec_t v, input int tag);
      exp_t e;
      @(negedge clock);
      reset = 1'b0;
      drive(v.valid, v.addr);
      #1;
      compareValue($sformatf("v%0d_ready", tag), 64'(req_ready), 64'(v.ready));
      if (v.p1 >= 0) begin
         last1_addr = v.addr[v.p1];
         last1_data = mk_data(v.addr[v.p1], v.p1);
      end
      if (v.p2 >= 0) begin
         last2_addr = v.addr[v.p2];
         last2_data = mk_data(v.addr[v.p2], v.p2);
      end
      if (((v.valid & ~v.ready) != 4'b0000) && (exp_cnt != 16'hFFFF)) begin
         exp_cnt = exp_cnt + 16'd1;
      end
      e.p1v = (v.p1 >= 0);
      e.p1a = last1_addr;
      e.p1d = last1_data;
      e.p2v = (v.p2 >= 0);
      e.p2a = last2_addr;
      e.p2d = last2_data;
      e.cnt = exp_cnt;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      checkOutput(tag);
   endtask

   // Assert reset with every requester valid: no grants may be issued and
   // every piece of state must read zero after the edge. Reset stays high
   // until the next applyStimulus releases it.
   task automatic doReset(input string name);
      @(negedge clock);
      reset = 1'b1;
      drive(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1});
      #1;
      compareValue({name, "_ready"}, 64'(req_ready), 64'd0);
      @(posedge clock);
      #1;
      compareValue({name, "_p1_valid"}, 64'(p1_valid), 64'd0);
      compareValue({name, "_p2_valid"}, 64'(p2_valid), 64'd0);
      compareValue({name, "_p1_addr"}, 64'(p1_addr), 64'd0);
      compareValue({name, "_p2_addr"}, 64'(p2_addr), 64'd0);
      compareValue({name, "_p1_data"}, p1_data, 64'd0);
      compareValue({name, "_p2_data"}, p2_data, 64'd0);
      compareValue({name, "_count"}, 64'(cont_count), 64'd0);
      last1_addr = '0;
      last1_data = '0;
      last2_addr = '0;
      last2_data = '0;
      exp_cnt    = '0;
   endtask

   vec_t vecs[14];
   vec_t all4;

   initial begin
      // valid, addr3..addr0, ready, port1 requester, port2 requester
      vecs[0]  = mk_vec(4'b0001, 5'd0,  5'd0,  5'd0,  5'd3,  4'b0001, 0, -1);
      vecs[1]  = mk_vec(4'b0000, 5'd0,  5'd0,  5'd0,  5'd0,  4'b0000, -1, -1);
      vecs[2]  = mk_vec(4'b1000, 5'd5,  5'd0,  5'd0,  5'd0,  4'b1000, 3, -1);
      vecs[3]  = mk_vec(4'b1111, 5'd4,  5'd3,  5'd2,  5'd1,  4'b0011, 0, 1);
      vecs[4]  = mk_vec(4'b1111, 5'd4,  5'd3,  5'd2,  5'd1,  4'b1100, 2, 3);
      vecs[5]  = mk_vec(4'b0011, 5'd0,  5'd0,  5'd2,  5'd1,  4'b0011, 0, 1);
      vecs[6]  = mk_vec(4'b1000, 5'd6,  5'd0,  5'd0,  5'd0,  4'b1000, 3, -1);
      vecs[7]  = mk_vec(4'b0111, 5'd0,  5'd9,  5'd7,  5'd7,  4'b0101, 0, 2);
      vecs[8]  = mk_vec(4'b0010, 5'd0,  5'd0,  5'd7,  5'd0,  4'b0010, 1, -1);
      vecs[9]  = mk_vec(4'b0100, 5'd0,  5'd10, 5'd0,  5'd0,  4'b0100, 2, -1);
      vecs[10] = mk_vec(4'b1001, 5'd11, 5'd0,  5'd0,  5'd12, 4'b1001, 3, 0);
      vecs[11] = mk_vec(4'b0011, 5'd0,  5'd0,  5'd14, 5'd13, 4'b0011, 1, 0);
      vecs[12] = mk_vec(4'b1111, 5'd15, 5'd15, 5'd15, 5'd15, 4'b0010, 1, -1);
      vecs[13] = mk_vec(4'b1101, 5'd15, 5'd15, 5'd0,  5'd15, 4'b0100, 2, -1);
      all4     = mk_vec(4'b1111, 5'd4,  5'd3,  5'd2,  5'd1,  4'b0011, 0, 1);

      doReset("reset0");

      for (int n = 0; n < 14; n++) begin
         applyStimulus(vecs[n], n);
      end

      // Two requesters fight over register 7 forever, so one is always
      // left waiting and the counter must climb to all-ones and stay.
      @(negedge clock);
      reset = 1'b0;
      drive(4'b0011, {5'd0, 5'd0, 5'd7, 5'd7});
      repeat (66000) @(posedge clock);
      #1;
      compareValue("count_saturated", 64'(cont_count), 64'hFFFF);
      @(posedge clock);
      #1;
      compareValue("count_no_wrap", 64'(cont_count), 64'hFFFF);

      // Reset in the middle of traffic, with the pointer left at 2.
      doReset("reset1");
      applyStimulus(all4, 100);
      doReset("reset_mid");
      applyStimulus(all4, 101);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
